// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: COM-based byte alignment, lock after BC_COUNT aligned COMs,
// then one registered byte per 8 clocks. Define SP_LOS_EN to drop lock after LOS_BYTES bytes without a COM.
module serial_paralelo_rx #(
    parameter logic [7:0]  COM       = 8'hBC,
    parameter logic [7:0]  IDLE      = 8'h7C,
    parameter int unsigned BC_COUNT  = 4,
    parameter int unsigned LOS_BYTES = 64
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_ALIGNED,
        ST_ACTIVE
    } state_t;

    state_t     state_q, state_d;
    // Only the last 7 bits are ever needed; the 8th is the incoming data_in.
    logic [6:0] sr_q, sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] com_cnt_q, com_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       strobe_q, strobe_d;
    logic       active_q, active_d;

    logic [7:0] nxt;
    logic       nxt_is_com;
    logic       boundary;
    logic [3:0] com_cnt_inc;

`ifdef SP_LOS_EN
    logic [7:0] los_cnt_q, los_cnt_d;
    logic [7:0] los_cnt_inc;
`else
    logic unused_los;
    assign unused_los = ^32'(LOS_BYTES);
`endif

    assign nxt         = {sr_q, data_in};
    assign nxt_is_com  = (nxt == COM);
    assign boundary    = (bit_cnt_q == 3'd7);
    assign com_cnt_inc = com_cnt_q + 4'd1;
`ifdef SP_LOS_EN
    assign los_cnt_inc = los_cnt_q + 8'd1;
`endif

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        sr_d      = nxt[6:0];
        bit_cnt_d = bit_cnt_q;
        com_cnt_d = com_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        strobe_d  = 1'b0;
        active_d  = active_q;
`ifdef SP_LOS_EN
        los_cnt_d = los_cnt_q;
`endif

        case (state_q)
            ST_UNLOCKED: begin
                if (nxt_is_com) begin
                    bit_cnt_d = 3'd0;
                    com_cnt_d = 4'd1;
                    if (BC_COUNT == 32'd1) begin
                        state_d  = ST_ACTIVE;
                        active_d = 1'b1;
`ifdef SP_LOS_EN
                        los_cnt_d = 8'd0;
`endif
                    end else begin
                        state_d = ST_ALIGNED;
                    end
                end
            end

            ST_ALIGNED: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    if (nxt_is_com) begin
                        com_cnt_d = com_cnt_inc;
                        if (com_cnt_inc == 4'(BC_COUNT)) begin
                            state_d  = ST_ACTIVE;
                            active_d = 1'b1;
`ifdef SP_LOS_EN
                            los_cnt_d = 8'd0;
`endif
                        end
                    end else begin
                        state_d   = ST_UNLOCKED;
                        com_cnt_d = 4'd0;
                    end
                end
            end

            ST_ACTIVE: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    data_d   = nxt;
                    strobe_d = 1'b1;
                    valid_d  = (nxt != IDLE) && !nxt_is_com;
`ifdef SP_LOS_EN
                    if (nxt_is_com) begin
                        los_cnt_d = 8'd0;
                    end else if (los_cnt_inc == 8'(LOS_BYTES)) begin
                        state_d   = ST_UNLOCKED;
                        active_d  = 1'b0;
                        valid_d   = 1'b0;
                        com_cnt_d = 4'd0;
                        los_cnt_d = 8'd0;
                    end else begin
                        los_cnt_d = los_cnt_inc;
                    end
`endif
                end
            end

            default: begin
                state_d = ST_UNLOCKED;
            end
        endcase
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q   <= ST_UNLOCKED;
            sr_q      <= 7'd0;
            bit_cnt_q <= 3'd0;
            com_cnt_q <= 4'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
            active_q  <= 1'b0;
`ifdef SP_LOS_EN
            los_cnt_q <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            strobe_q  <= strobe_d;
            active_q  <= active_d;
`ifdef SP_LOS_EN
            los_cnt_q <= los_cnt_d;
`endif
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed bench for serial_paralelo_rx: expected bytes are queued as they are sent and
// popped when byte_strobe fires; outputs are checked 1 ns after every rising edge.
module tb_serial_paralelo_rx;

    logic       clk_32f;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    typedef struct packed {
        logic [7:0] d;
        logic       v;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] cur_data;
    logic       cur_valid;
    logic       exp_active;
    int         errors;
    int         checks;

`ifdef SP_LOS_EN
    localparam bit LOS = 1'b1;
`else
    localparam bit LOS = 1'b0;
`endif

    serial_paralelo_rx dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_in    (data_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .byte_strobe(byte_strobe),
        .active     (active)
    );

    initial begin
        clk_32f = 1'b0;
        forever #5 clk_32f = ~clk_32f;
    end

    function automatic logic is_data(input logic [7:0] b);
        return (b != 8'h7C) && (b != 8'hBC);
    endfunction

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @%0t: got %b expected %b", tag, $time, obs, exp);
        end
    endtask

    task automatic check_cycle();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk1("strobe_idle", byte_strobe, 1'b0);
        end else begin
            e = exp_q.pop_front();
            chk1("strobe_due", byte_strobe, 1'b1);
            cur_data  = e.d;
            cur_valid = e.v;
        end
        chk8("data_out", data_out, cur_data);
        chk1("valid_out", valid_out, cur_valid);
        chk1("active", active, exp_active);
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
        check_cycle();
    endtask

    // MSB first; expectation for the byte is armed just before its last bit is sampled.
    task automatic send_byte(input logic [7:0] b, input logic push, input logic act_after,
                             input logic vld);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) begin
                if (push) exp_q.push_back('{d: b, v: vld});
                exp_active = act_after;
            end
            send_bit(b[i]);
        end
    endtask

    task automatic send_data(input logic [7:0] b);
        send_byte(b, 1'b1, 1'b1, is_data(b));
    endtask

    task automatic clear_expect();
        exp_q.delete();
        cur_data   = 8'h00;
        cur_valid  = 1'b0;
        exp_active = 1'b0;
    endtask

    task automatic check_reset_now(input string tag);
        chk8({tag, "_data"}, data_out, 8'h00);
        chk1({tag, "_valid"}, valid_out, 1'b0);
        chk1({tag, "_strobe"}, byte_strobe, 1'b0);
        chk1({tag, "_active"}, active, 1'b0);
    endtask

    // Async reset applied between edges, held over a few edges with data toggling.
    task automatic apply_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        check_reset_now(tag);
        clear_expect();
        for (int i = 0; i < 3; i++) send_bit(1'(i[0]));
        reset = 1'b0;
    endtask

    task automatic lock4();
        for (int i = 0; i < 3; i++) send_byte(8'hBC, 1'b0, 1'b0, 1'b0);
        send_byte(8'hBC, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        reset   = 1'b0;
        data_in = 1'b0;
        clear_expect();

        // 1: reset, 3 garbage bits, 4 COMs -> active on the 35th bit, no strobe
        apply_reset("rst_init");
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        lock4();

        // 2: data bytes strobed 8 cycles apart
        send_data(8'h55);
        send_data(8'hCC);

        // 4: IDLE and COM flagged invalid, data valid
        send_data(8'h7C);
        send_data(8'hBC);
        send_data(8'hA8);

        // 5: reset 3 bits into a byte while active; relock needs 4 fresh COMs
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        apply_reset("rst_mid");
        lock4();
        send_data(8'h3A);

        // 3: a non-COM byte during alignment drops back to search
        apply_reset("rst_t3");
        for (int i = 0; i < 3; i++) send_byte(8'hBC, 1'b0, 1'b0, 1'b0);
        send_byte(8'h12, 1'b0, 1'b0, 1'b0);
        lock4();
        send_data(8'h96);

        // 6: 64 data bytes without a COM; loss of sync only when enabled
        apply_reset("rst_t6");
        lock4();
        for (int i = 1; i <= 64; i++) begin
            if (LOS && i == 64) send_byte(8'h11, 1'b1, 1'b0, 1'b0);
            else send_data(8'h11);
        end
        if (LOS) begin
            send_byte(8'h11, 1'b0, 1'b0, 1'b0);
            send_byte(8'h11, 1'b0, 1'b0, 1'b0);
        end else begin
            send_data(8'h22);
        end

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL pending_strobes: got %0d left expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
